// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI transmit period scheduler.
package hdmi_pkg;

  typedef enum logic [2:0] {
    CONTROL      = 3'd0,
    VIDEO        = 3'd1,
    VIDEO_GUARD  = 3'd2,
    ISLAND       = 3'd3,
    ISLAND_GUARD = 3'd4
  } period_t;

  typedef enum logic [2:0] {
    ISL_IDLE,
    ISL_PRE,
    ISL_LGUARD,
    ISL_PACKET,
    ISL_TGUARD,
    ISL_DONE
  } island_state_t;

  localparam logic [3:0] CTL_VIDEO_PRE  = 4'b0001;
  localparam logic [3:0] CTL_ISLAND_PRE = 4'b0101;

  localparam int PRE_LEN    = 8;
  localparam int GUARD_LEN  = 2;
  localparam int PACKET_LEN = 32;
  localparam int MIN_CTRL   = 12;

  localparam int CX_W = 12;
  localparam int CY_W = 11;

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// Scheduler-to-encoder/assembler bundle: raster position, sync, period and packet handshake.
interface hdmi_period_scheduler_if
  import hdmi_pkg::*;
();
  logic                packet_valid;
  logic [CX_W-1:0]     cx;
  logic [CY_W-1:0]     cy;
  logic                hsync;
  logic                vsync;
  period_t             mode;
  logic [3:0]          ctl;
  logic [4:0]          packet_idx;
  logic                packet_pop;

  modport master (
    input  packet_valid,
    output cx, cy, hsync, vsync, mode, ctl, packet_idx, packet_pop
  );

  modport slave (
    output packet_valid,
    input  cx, cy, hsync, vsync, mode, ctl, packet_idx, packet_pop
  );
endinterface

// File: rtl/video_timing_counter.sv
// Raster counters and sync generation; also exposes the upcoming pixel position and its next line.
module video_timing_counter
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic            clk_pixel,
  input  logic            reset,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            hsync,
  output logic            vsync,
  output logic [CX_W-1:0] nx_cx,
  output logic [CY_W-1:0] nx_cy,
  output logic [CY_W-1:0] ny
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CX_W-1:0] H_LAST = CX_W'(H_TOTAL - 1);
  localparam logic [CX_W-1:0] HS_BEG = CX_W'(H_ACTIVE + H_FRONT);
  localparam logic [CX_W-1:0] HS_END = CX_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CY_W-1:0] V_LAST = CY_W'(V_TOTAL - 1);
  localparam logic [CY_W-1:0] VS_BEG = CY_W'(V_ACTIVE + V_FRONT);
  localparam logic [CY_W-1:0] VS_END = CY_W'(V_ACTIVE + V_FRONT + V_SYNC);

  // Everything registered here is derived from the upcoming position so all outputs stay aligned.
  always_comb begin
    nx_cx = (cx == H_LAST) ? '0 : cx + CX_W'(1);
    nx_cy = cy;
    if (cx == H_LAST) nx_cy = (cy == V_LAST) ? '0 : cy + CY_W'(1);
    ny = (nx_cy == V_LAST) ? '0 : nx_cy + CY_W'(1);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cx    <= '0;
      cy    <= '0;
      hsync <= !HSYNC_POL;
      vsync <= !VSYNC_POL;
    end else begin
      cx    <= nx_cx;
      cy    <= nx_cy;
      hsync <= (nx_cx >= HS_BEG && nx_cx < HS_END) ? HSYNC_POL : !HSYNC_POL;
      vsync <= (nx_cy >= VS_BEG && nx_cy < VS_END) ? VSYNC_POL : !VSYNC_POL;
    end
  end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer: video/preamble/guard timing plus one data island per line.
// Define HDMI_DATA_ISLAND_EN to build the island FSM; otherwise the block behaves as plain DVI.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                     clk_pixel,
  input  logic                     reset,
  hdmi_period_scheduler_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  if (H_TOTAL - H_ACTIVE < 4 + PRE_LEN + 2 * GUARD_LEN + PACKET_LEN + MIN_CTRL + 10) begin : g_bad_blanking
    $error("hdmi_period_scheduler: horizontal blanking too short for island plus video preamble");
  end

  localparam logic [CX_W-1:0] H_ACT      = CX_W'(H_ACTIVE);
  localparam logic [CX_W-1:0] VPRE_BEG   = CX_W'(H_TOTAL - 10);
  localparam logic [CX_W-1:0] VPRE_END   = CX_W'(H_TOTAL - 3);
  localparam logic [CX_W-1:0] VGRD_BEG   = CX_W'(H_TOTAL - 2);
  localparam logic [CY_W-1:0] V_ACT      = CY_W'(V_ACTIVE);

  logic [CX_W-1:0] cx, nx_cx;
  logic [CY_W-1:0] cy, nx_cy, ny;
  logic            hsync, vsync;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
    .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .clk_pixel(clk_pixel), .reset(reset),
    .cx(cx), .cy(cy), .hsync(hsync), .vsync(vsync),
    .nx_cx(nx_cx), .nx_cy(nx_cy), .ny(ny)
  );

  logic       isl_busy;
  period_t    isl_mode;
  logic [3:0] isl_ctl;
  logic [4:0] isl_idx;
  logic       isl_pop;

`ifdef HDMI_DATA_ISLAND_EN
  localparam logic [CX_W-1:0] SAMPLE_X    = CX_W'(H_ACTIVE + 3);
  localparam logic [4:0]      PRE_LAST    = 5'(PRE_LEN - 1);
  localparam logic [4:0]      GUARD_LAST  = 5'(GUARD_LEN - 1);
  localparam logic [4:0]      PACKET_LAST = 5'(PACKET_LEN - 1);

  island_state_t state, state_nx;
  logic [4:0]    cnt, cnt_nx;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state <= ISL_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // state/cnt describe the pixel currently on cx; the _nx values describe the upcoming one.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 5'd1;
    isl_busy = 1'b0;
    isl_mode = CONTROL;
    isl_ctl  = 4'b0000;
    isl_idx  = '0;
    isl_pop  = 1'b0;
    case (state)
      ISL_IDLE: begin
        cnt_nx = '0;
        if (cx == SAMPLE_X && bus.packet_valid) state_nx = ISL_PRE;
      end
      ISL_PRE:    if (cnt == PRE_LAST)    begin state_nx = ISL_LGUARD; cnt_nx = '0; end
      ISL_LGUARD: if (cnt == GUARD_LAST)  begin state_nx = ISL_PACKET; cnt_nx = '0; end
      ISL_PACKET: if (cnt == PACKET_LAST) begin state_nx = ISL_TGUARD; cnt_nx = '0; end
      ISL_TGUARD: if (cnt == GUARD_LAST)  begin state_nx = ISL_DONE;   cnt_nx = '0; end
      ISL_DONE: begin
        cnt_nx = '0;
        if (cx == CX_W'(H_TOTAL - 1)) state_nx = ISL_IDLE;
      end
      default: begin
        state_nx = ISL_IDLE;
        cnt_nx   = '0;
      end
    endcase
    case (state_nx)
      ISL_PRE:    begin isl_busy = 1'b1; isl_ctl = CTL_ISLAND_PRE; end
      ISL_LGUARD: begin isl_busy = 1'b1; isl_mode = ISLAND_GUARD; end
      ISL_PACKET: begin isl_busy = 1'b1; isl_mode = ISLAND; isl_idx = cnt_nx; end
      ISL_TGUARD: begin
        isl_busy = 1'b1;
        isl_mode = ISLAND_GUARD;
        isl_pop  = (cnt_nx == GUARD_LAST);
      end
      default: ;
    endcase
  end
`else
  logic unused_packet_valid;
  assign unused_packet_valid = bus.packet_valid;
  assign isl_busy = 1'b0;
  assign isl_mode = CONTROL;
  assign isl_ctl  = 4'b0000;
  assign isl_idx  = '0;
  assign isl_pop  = 1'b0;
`endif

  period_t    mode_nx, mode_r;
  logic [3:0] ctl_nx, ctl_r;
  logic [4:0] idx_r;
  logic       pop_r;

  always_comb begin
    mode_nx = CONTROL;
    ctl_nx  = 4'b0000;
    if (isl_busy) begin
      mode_nx = isl_mode;
      ctl_nx  = isl_ctl;
    end else if (nx_cx < H_ACT && nx_cy < V_ACT) begin
      mode_nx = VIDEO;
    end else if (ny < V_ACT && nx_cx >= VPRE_BEG && nx_cx <= VPRE_END) begin
      ctl_nx = CTL_VIDEO_PRE;
    end else if (ny < V_ACT && nx_cx >= VGRD_BEG) begin
      mode_nx = VIDEO_GUARD;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      mode_r <= CONTROL;
      ctl_r  <= '0;
      idx_r  <= '0;
      pop_r  <= 1'b0;
    end else begin
      mode_r <= mode_nx;
      ctl_r  <= ctl_nx;
      idx_r  <= isl_idx;
      pop_r  <= isl_pop;
    end
  end

  assign bus.cx         = cx;
  assign bus.cy         = cy;
  assign bus.hsync      = hsync;
  assign bus.vsync      = vsync;
  assign bus.mode       = mode_r;
  assign bus.ctl        = ctl_r;
  assign bus.packet_idx = idx_r;
  assign bus.packet_pop = pop_r;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler on a shrunken raster: fixed vectors, corner sequences, random packet_valid/reset.
module tb_hdmi_period_scheduler;
  import hdmi_pkg::*;

  localparam int HA = 20, HF = 16, HS = 30, HB = 24;
  localparam int VA = 6,  VF = 2,  VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam bit HP = 1'b1, VP = 1'b0;
`ifdef HDMI_DATA_ISLAND_EN
  localparam bit ISL_EN = 1'b1;
`else
  localparam bit ISL_EN = 1'b0;
`endif

  logic clk_pixel = 1'b0;
  logic reset = 1'b1;
  hdmi_period_scheduler_if bus();

  hdmi_period_scheduler #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int total = 0;
  int bad = 0;

  typedef struct {
    int cx, cy;
    period_t mode;
    logic [3:0] ctl;
    logic hs, vs;
    logic [4:0] idx;
    logic pop;
  } obs_t;

  typedef struct {
    int adv;
    int cx, cy;
    period_t mode;
    logic [3:0] ctl;
    logic hs, vs;
  } vec_t;

  // Reference position and island bookkeeping, kept in plain integers.
  int mx = 0, my = 0;
  bit m_isl = 0, m_fresh = 1;

  function automatic obs_t expect_pix(int x, int y, bit isl, bit fresh);
    obs_t e;
    int ny, off;
    e.cx = x; e.cy = y;
    e.hs = (x >= HA + HF && x < HA + HF + HS) ? HP : !HP;
    e.vs = (y >= VA + VF && y < VA + VF + VS) ? VP : !VP;
    e.mode = CONTROL; e.ctl = 4'b0000; e.idx = '0; e.pop = 1'b0;
    ny = (y == VT - 1) ? 0 : y + 1;
    off = x - (HA + 4);
    if (fresh) begin
      e.mode = CONTROL;
    end else if (isl && off >= 0 && off < 44) begin
      if (off < 8) e.ctl = 4'b0101;
      else if (off < 10 || off >= 42) e.mode = ISLAND_GUARD;
      else begin e.mode = ISLAND; e.idx = 5'(off - 10); end
      e.pop = (off == 43);
    end else if (x < HA && y < VA) e.mode = VIDEO;
    else if (ny < VA && x >= HT - 10 && x <= HT - 3) e.ctl = 4'b0001;
    else if (ny < VA && x >= HT - 2) e.mode = VIDEO_GUARD;
    return e;
  endfunction

  task automatic check_model();
    obs_t e;
    e = expect_pix(mx, my, m_isl, m_fresh);
    total++;
    if (int'(bus.cx) != e.cx || int'(bus.cy) != e.cy || bus.mode != e.mode || bus.ctl != e.ctl ||
        bus.hsync != e.hs || bus.vsync != e.vs || bus.packet_idx != e.idx || bus.packet_pop != e.pop) begin
      bad++;
      $display("FAIL model: got cx=%0d cy=%0d mode=%0d ctl=%b hs=%b vs=%b idx=%0d pop=%b, want cx=%0d cy=%0d mode=%0d ctl=%b hs=%b vs=%b idx=%0d pop=%b",
               bus.cx, bus.cy, bus.mode, bus.ctl, bus.hsync, bus.vsync, bus.packet_idx, bus.packet_pop,
               e.cx, e.cy, e.mode, e.ctl, e.hs, e.vs, e.idx, e.pop);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input bit r, input bit pv);
    reset = r;
    bus.packet_valid = pv;
    if (r) begin
      mx = 0; my = 0; m_isl = 0; m_fresh = 1;
    end else begin
      if (ISL_EN && mx == HA + 3 && pv) m_isl = 1;
      m_fresh = 0;
      if (mx == HT - 1) begin
        mx = 0; m_isl = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else mx++;
    end
    @(posedge clk_pixel);
    #1;
    check_model();
  endtask

  vec_t vt[20];
  int vid, pops, islc, isl6, rec_mode, rec_idx;

  initial begin
    vt[0]  = '{0,   0,  0,  CONTROL,     4'b0000, 1'b0, 1'b1};
    vt[1]  = '{1,   1,  0,  VIDEO,       4'b0000, 1'b0, 1'b1};
    vt[2]  = '{18,  19, 0,  VIDEO,       4'b0000, 1'b0, 1'b1};
    vt[3]  = '{1,   20, 0,  CONTROL,     4'b0000, 1'b0, 1'b1};
    vt[4]  = '{16,  36, 0,  CONTROL,     4'b0000, 1'b1, 1'b1};
    vt[5]  = '{29,  65, 0,  CONTROL,     4'b0000, 1'b1, 1'b1};
    vt[6]  = '{1,   66, 0,  CONTROL,     4'b0000, 1'b0, 1'b1};
    vt[7]  = '{14,  80, 0,  CONTROL,     4'b0001, 1'b0, 1'b1};
    vt[8]  = '{7,   87, 0,  CONTROL,     4'b0001, 1'b0, 1'b1};
    vt[9]  = '{1,   88, 0,  VIDEO_GUARD, 4'b0000, 1'b0, 1'b1};
    vt[10] = '{1,   89, 0,  VIDEO_GUARD, 4'b0000, 1'b0, 1'b1};
    vt[11] = '{1,   0,  1,  VIDEO,       4'b0000, 1'b0, 1'b1};
    vt[12] = '{440, 80, 5,  CONTROL,     4'b0000, 1'b0, 1'b1};
    vt[13] = '{8,   88, 5,  CONTROL,     4'b0000, 1'b0, 1'b1};
    vt[14] = '{2,   0,  6,  CONTROL,     4'b0000, 1'b0, 1'b1};
    vt[15] = '{180, 0,  8,  CONTROL,     4'b0000, 1'b0, 1'b0};
    vt[16] = '{180, 0,  10, CONTROL,     4'b0000, 1'b0, 1'b1};
    vt[17] = '{260, 80, 12, CONTROL,     4'b0001, 1'b0, 1'b1};
    vt[18] = '{8,   88, 12, VIDEO_GUARD, 4'b0000, 1'b0, 1'b1};
    vt[19] = '{2,   0,  0,  VIDEO,       4'b0000, 1'b0, 1'b1};

    bus.packet_valid = 1'b0;
    repeat (2) tick(1'b1, 1'b0);
    chk("rst_idx", int'(bus.packet_idx), 0);
    chk("rst_pop", int'(bus.packet_pop), 0);

    for (int i = 0; i < 20; i++) begin
      repeat (vt[i].adv) tick(1'b0, 1'b0);
      total++;
      if (int'(bus.cx) != vt[i].cx || int'(bus.cy) != vt[i].cy || bus.mode != vt[i].mode ||
          bus.ctl != vt[i].ctl || bus.hsync != vt[i].hs || bus.vsync != vt[i].vs) begin
        bad++;
        $display("FAIL vec[%0d]: got cx=%0d cy=%0d mode=%0d ctl=%b hs=%b vs=%b, want cx=%0d cy=%0d mode=%0d ctl=%b hs=%b vs=%b",
                 i, bus.cx, bus.cy, bus.mode, bus.ctl, bus.hsync, bus.vsync,
                 vt[i].cx, vt[i].cy, vt[i].mode, vt[i].ctl, vt[i].hs, vt[i].vs);
      end
    end

    // One full frame with packet_valid held high.
    vid = 0; pops = 0; islc = 0;
    repeat (HT * VT) begin
      tick(1'b0, 1'b1);
      if (bus.mode == VIDEO) vid++;
      if (bus.mode == ISLAND) islc++;
      if (bus.packet_pop) pops++;
    end
    chk("frame_video", vid, HA * VA);
    chk("frame_island", islc, ISL_EN ? 32 * VT : 0);
    chk("frame_pops", pops, ISL_EN ? VT : 0);

    // packet_valid raised across the sample point of line 5 only, dropped mid-island.
    pops = 0; isl6 = 0; rec_mode = -1; rec_idx = -1;
    for (int n = 0; n < HT * VT; n++) begin
      if (mx == 0 && my == 7) break;
      tick(1'b0, (my == 5 && mx >= HA + 3 && mx < HA + 20));
      if (bus.packet_pop) pops++;
      if (mx == HA + 20 && my == 5) begin rec_mode = int'(bus.mode); rec_idx = int'(bus.packet_idx); end
      if (my == 6 && bus.mode != CONTROL && bus.mode != VIDEO && bus.mode != VIDEO_GUARD) isl6++;
    end
    chk("a_pops", pops, ISL_EN ? 1 : 0);
    chk("a_mode_mid", rec_mode, ISL_EN ? int'(ISLAND) : int'(CONTROL));
    chk("a_idx_mid", rec_idx, ISL_EN ? 6 : 0);
    chk("a_line6_island", isl6, 0);

    // Reset in the middle of the packet on line 7.
    for (int n = 0; n < HT; n++) begin
      if (mx == HA + 30) break;
      tick(1'b0, 1'b1);
    end
    chk("b_mode_before", int'(bus.mode), ISL_EN ? int'(ISLAND) : int'(CONTROL));
    tick(1'b1, 1'b1);
    chk("b_rst_cx", int'(bus.cx), 0);
    chk("b_rst_mode", int'(bus.mode), int'(CONTROL));
    chk("b_rst_pop", int'(bus.packet_pop), 0);
    chk("b_rst_hs", int'(bus.hsync), int'(!HP));
    tick(1'b0, 1'b0);
    chk("b_resume_cx", int'(bus.cx), 1);
    pops = 0;
    repeat (2 * HT) begin
      tick(1'b0, 1'b0);
      if (bus.packet_pop) pops++;
    end
    chk("b_no_pop", pops, 0);

    // Random packet_valid with occasional resets.
    repeat (3 * HT * VT) tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_period_scheduler.md
# hdmi_period_scheduler

Per-pixel period sequencer for the HDMI transmit path, in the `clk_pixel` domain ahead of the TMDS encoders and the 10:1 serializer. It generates raster counters and sync, and decides each cycle whether the three channels carry control, video preamble/guard, video data, or a data island. It also hands out the one-packet-per-line island slot to the packet assembler through a valid/pop handshake.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FRONT` / `H_SYNC` / `H_BACK`, 16 / 96 / 48, horizontal blanking segments
- `V_ACTIVE`, 480, active lines
- `V_FRONT` / `V_SYNC` / `V_BACK`, 10 / 2 / 33, vertical blanking segments
- `HSYNC_POL` / `VSYNC_POL`, 0 / 0, active level of the sync outputs
- `clk_pixel` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `packet_valid` in 1: assembler holds a complete 32-cycle packet (level).
- `cx` out 12: horizontal position.
- `cy` out 11: vertical position.
- `hsync`, `vsync` out 1: sync at parameter polarity.
- `mode` out 3: `period_t` code for this pixel.
- `ctl` out 4: CTL3..CTL0 for control periods.
- `packet_idx` out 5: packet cycle index 0..31.
- `packet_pop` out 1: 1-cycle pulse, packet consumed.

## Operation
- `H_TOTAL` is the sum of the four H parameters. `V_TOTAL` is the sum of the four V parameters.
- `cx` counts 0..H_TOTAL-1 and wraps. `cy` increments on that wrap and itself wraps at V_TOTAL-1.
- Active video: `cx<H_ACTIVE && cy<V_ACTIVE`, giving `mode=VIDEO`.
- `hsync` is asserted for `cx` in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
- `vsync` is asserted for `cy` in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
- The next line is `ny = (cy==V_TOTAL-1) ? 0 : cy+1`. When `ny<V_ACTIVE`:
  - Video preamble at `cx` in [H_TOTAL-10, H_TOTAL-3]: `mode=CONTROL`, `ctl=4'b0001`.
  - Video guard at `cx` in [H_TOTAL-2, H_TOTAL-1]: `mode=VIDEO_GUARD`.
- Island FSM states: IDLE, PRE(8 cycles), LGUARD(2), PACKET(32), TGUARD(2), DONE.
  - In IDLE, `packet_valid` is sampled at `cx==H_ACTIVE+3` on any line.
  - If high, PRE starts at `cx=H_ACTIVE+4` with `mode=CONTROL` and `ctl=4'b0101`.
  - LGUARD and TGUARD output `mode=ISLAND_GUARD`.
  - PACKET outputs `mode=ISLAND`, with `packet_idx` running 0..31.
  - `packet_pop` pulses on the last TGUARD cycle.
  - DONE holds until the `cx` wrap, then returns to IDLE. At most one island per line.
  - `packet_valid` is ignored outside the sample cycle. Dropping it mid-island does not abort the island.
- All other cycles: `mode=CONTROL`, `ctl=0`.
- Elaboration check: `H_TOTAL-H_ACTIVE >= 70`, covering 4 + island 44 + 12 minimum control + 10 video preamble/guard. Fail elaboration otherwise.

## Timing
- All outputs are registered. `cx`, `cy`, `hsync`, `vsync`, `mode`, `ctl`, `packet_idx` and `packet_pop` in one cycle all describe the same pixel.
- Reset values: `cx=0`, `cy=0`, `mode=CONTROL`, `ctl=0`, `hsync=!HSYNC_POL`, `vsync=!VSYNC_POL`, `packet_idx=0`, `packet_pop=0`, FSM=IDLE.
- The first cycle after reset release reports `cx=1`. Pixel (0,0) of the partial first frame is CONTROL. The first fully framed line is `cy=1`.
- Reset mid-island: the island aborts and there is no `packet_pop`. The assembler keeps its packet.
- The island period and `hsync`/`vsync` may overlap. Sync outputs remain valid in every mode.

## Configuration
- `HDMI_DATA_ISLAND_EN` defined: island FSM is present as described.
- Undefined (DVI mode): FSM removed and `packet_valid` ignored. `packet_pop=0` and `packet_idx=0` always. `mode` is never ISLAND or ISLAND_GUARD, and `ctl` is never `4'b0101`.

## Structure
- Package `hdmi_pkg` holds:
  - `typedef enum logic [2:0] period_t {CONTROL=0, VIDEO=1, VIDEO_GUARD=2, ISLAND=3, ISLAND_GUARD=4}`.
  - Constants `CTL_VIDEO_PRE=4'b0001`, `CTL_ISLAND_PRE=4'b0101`.
  - Lengths `PRE_LEN=8`, `GUARD_LEN=2`, `PACKET_LEN=32`, `MIN_CTRL=12`.
- Sub-module `video_timing_counter` provides `cx`, `cy`, `hsync`, `vsync` and `ny`. The scheduler adds period logic and the island FSM.

## Test plan
- Default params, island disabled, 2 frames → `mode=VIDEO` exactly 640×480 per frame. Preamble `ctl=0001` at `cx` 790..797 and VIDEO_GUARD at 798..799 on `cy=524` and `cy` 0..478 only.
- Sync check → `hsync=0` for `cx` 656..751. `vsync=0` for `cy` 490..491. Line length 800, frame length 525.
- Island enabled, `packet_valid=1` constantly → every line shows PRE 644..651, ISLAND_GUARD 652..653, ISLAND 654..685 with `packet_idx` 0..31, ISLAND_GUARD 686..687, and a single `packet_pop` at `cx=687`.
- `packet_valid` high only at `cx=643` of `cy=5`, then low at `cx=660` → full island on line 5 with pop. No island on line 6.
- `reset` asserted at `cx=670` during PACKET → next cycle all outputs at reset values. No `packet_pop`. After release, `cx` resumes from 1.
- Island disabled, `packet_valid=1` → no ISLAND modes, `packet_pop` stays 0, and video timing is identical to the first scenario.
